// File: rtl/apb2_types.sv
// Shared types and width constants for the APB2 master.
// The response struct carries the widest supported data bus.
package apb2_types;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 8;
    localparam int APB_PROT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb2_master_state_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb2_rsp_t;

endpackage

// File: rtl/apb2_watchdog.sv
// Saturating ACCESS-phase cycle counter with a terminal flag.
// A limit of 0 disables the terminal flag entirely.
module apb2_watchdog #(
    parameter int limit = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = (limit > 0) ? $clog2(limit + 1) : 1;
    localparam logic [W-1:0] LAST = W'((limit > 0) ? limit - 1 : 0);

    logic [W-1:0] count;

    // Holds at LAST so the counter never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (limit != 0) && (count == LAST);

endmodule

// File: rtl/apb2_master.sv
// APB2 requester: single-beat command port to SETUP/ACCESS transfers,
// with a response port and an ACCESS-phase watchdog.
module apb2_master
    import apb2_types::*;
#(
    parameter int                    data_width     = APB_DATA_W,
    parameter int                    addr_width     = APB_ADDR_W,
    parameter int                    timeout_cycles = 256,
    parameter logic [APB_PROT_W-1:0] prot_value     = 3'b000
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [addr_width-1:0]   cmd_addr,
    input  logic [data_width-1:0]   cmd_wdata,
    input  logic [data_width/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [data_width-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [addr_width-1:0]   paddr,
    output logic [data_width-1:0]   pwdata,
    output logic [data_width/8-1:0] pstrb,
    output logic [APB_PROT_W-1:0]   pprot,
    input  logic [data_width-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    apb2_master_state_t state, state_next;
    apb2_rsp_t          rsp;
    logic               expired;
    logic               in_access;
    logic               done;
    logic               abort;

    assign in_access = (state == ACCESS);
    // pready outranks a simultaneous watchdog expiry
    assign done      = in_access && pready;
    assign abort     = in_access && !pready && expired;

    apb2_watchdog #(
        .limit(timeout_cycles)
    ) u_watchdog (
        .clk    (pclk),
        .rst    (preset),
        .clear  (!in_access),
        .en     (in_access && !pready),
        .expired(expired)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (done || abort) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            pwrite <= 1'b0;
            paddr  <= '0;
            pwdata <= '0;
            pstrb  <= '0;
            rsp    <= '0;
        end else begin
            if ((state == IDLE) && cmd_valid) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_write ? cmd_strb : '0;
            end
            if ((state == RESP) && rsp_ready) begin
                pstrb <= '0;
            end
            if (done) begin
                rsp.rdata   <= pwrite ? '0 : APB_DATA_W'(prdata);
                rsp.err     <= pslverr;
                rsp.timeout <= 1'b0;
            end else if (abort) begin
                rsp.rdata   <= '0;
                rsp.err     <= 1'b1;
                rsp.timeout <= 1'b1;
            end
        end
    end

    assign rsp_rdata   = rsp.rdata[data_width-1:0];
    assign rsp_err     = rsp.err;
    assign rsp_timeout = rsp.timeout;
    assign pprot       = prot_value;

endmodule

// File: tb/tb_apb2_master.sv
// Bench for apb2_master: vector table, reset corner cases and
// randomized transfers against a cycle-count reference model.
module tb_apb2_master;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          preset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_strb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 pclk = ~pclk;

    apb2_master #(
        .data_width    (DW),
        .addr_width    (AW),
        .timeout_cycles(TO),
        .prot_value    (3'b000)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pprot      (pprot),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        err;
        logic [31:0] rdata;
        logic        park;
        int          delay;
        logic        early;
        logic        keep;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, got, want, $time);
        end
    endtask

    // Cycles from acceptance edge to rsp_valid, and the response fields
    function automatic void model(input vec_t v, output int lat,
                                  output logic [31:0] rd,
                                  output logic e, output logic t);
        t   = (TO != 0) && (v.waits >= TO);
        lat = t ? 2 + TO : 3 + v.waits;
        rd  = (t || v.write) ? 32'h0 : v.rdata;
        e   = t | v.err;
    endfunction

    // Starts at a negedge (or IDLE cycle); ends at the negedge of IDLE
    task automatic xfer(input vec_t v);
        int          lat;
        int          k;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_e;
        logic        exp_t;
        logic [3:0]  exp_strb;
        lat = 0;
        k = 0;
        model(v, exp_lat, exp_rd, exp_e, exp_t);
        exp_strb  = v.write ? v.strb : 4'h0;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        rsp_ready = v.early;
        pready    = v.park;
        pslverr   = v.park & v.err;
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(posedge pclk);
            #1;
            @(negedge pclk);
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        if (!cmd_ready) return;
        for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
            @(posedge pclk);
            #1;
            if (cyc == 1) cmd_valid = v.keep;
            if (penable) begin
                pready  = (k >= v.waits);
                prdata  = v.rdata;
                pslverr = v.err;
                k++;
            end else begin
                pready  = v.park;
                prdata  = $urandom;
                pslverr = v.park & v.err;
            end
            @(negedge pclk);
            if (rsp_valid) begin
                lat = cyc;
            end else begin
                chk("psel", psel, 1);
                chk("penable", penable, 32'(cyc >= 2));
                chk("cmd_ready_busy", cmd_ready, 0);
                chk("paddr", paddr, v.addr);
                chk("pwrite", pwrite, v.write);
                chk("pwdata", pwdata, v.wdata);
                chk("pstrb", pstrb, exp_strb);
            end
        end
        chk("rsp_valid_seen", rsp_valid, 1);
        if (!rsp_valid) return;
        chk("latency", lat, exp_lat);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_e);
        chk("rsp_timeout", rsp_timeout, exp_t);
        chk("psel_resp", psel, 0);
        chk("penable_resp", penable, 0);
        if (!v.early) begin
            for (int d = 0; d < v.delay; d++) begin
                @(posedge pclk);
                #1;
                @(negedge pclk);
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_ready", cmd_ready, 0);
                chk("rsp_hold_psel", psel, 0);
                chk("rsp_hold_rdata", rsp_rdata, exp_rd);
                chk("rsp_hold_err", rsp_err, exp_e);
            end
            @(posedge pclk);
            #1;
            rsp_ready = 1'b1;
            @(negedge pclk);
            chk("rsp_valid_hs", rsp_valid, 1);
        end
        @(posedge pclk);
        #1;
        rsp_ready = 1'b0;
        @(negedge pclk);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_psel", psel, 0);
        chk("idle_pstrb", pstrb, 0);
        chk("idle_paddr", paddr, v.addr);
        chk("idle_pwrite", pwrite, v.write);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_psel"}, psel, 0);
        chk({tag, "_penable"}, penable, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_pwrite"}, pwrite, 0);
        chk({tag, "_paddr"}, paddr, 0);
        chk({tag, "_pwdata"}, pwdata, 0);
        chk({tag, "_pstrb"}, pstrb, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        vec_t rv;
        vecs[0]  = '{0, 8'h00, 32'h0, 4'hF, 0, 0, 32'h0000_0A55, 0, 0, 0, 0};
        vecs[1]  = '{1, 8'h10, 32'h5, 4'hF, 3, 0, 32'h1111_2222, 0, 0, 0, 0};
        vecs[2]  = '{0, 8'h04, 32'h0, 4'hF, 0, 1, 32'h0000_1234, 1, 1, 0, 0};
        vecs[3]  = '{0, 8'h08, 32'h0, 4'h0, 100, 0, 32'hDEAD_BEEF, 0, 0, 0, 0};
        vecs[4]  = '{1, 8'h20, 32'hCAFE, 4'h3, 1, 0, 32'h0, 0, 0, 0, 0};
        vecs[5]  = '{0, 8'h30, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D, 0, 5, 0, 1};
        vecs[6]  = '{0, 8'h30, 32'h0, 4'h0, 0, 0, 32'h1357_9BDF, 0, 0, 0, 0};
        vecs[7]  = '{1, 8'h44, 32'hA5A5, 4'h6, 2, 0, 32'h0, 1, 0, 1, 0};
        vecs[8]  = '{1, 8'h48, 32'h77, 4'h3, 0, 1, 32'h0, 0, 2, 0, 0};
        vecs[9]  = '{0, 8'h4C, 32'h0, 4'hF, 3, 0, 32'h2468_ACE0, 0, 0, 0, 0};
        vecs[10] = '{0, 8'h50, 32'h0, 4'hF, 4, 1, 32'h0F0F_0F0F, 1, 0, 0, 0};

        #12;
        reset_checks("reset");
        chk("pprot", pprot, 0);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        foreach (vecs[i]) xfer(vecs[i]);

        // Reset while penable is high
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h60;
        pready    = 1'b0;
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
        @(posedge pclk);
        #1;
        @(negedge pclk);
        chk("mid_penable", penable, 1);
        #2;
        preset = 1'b1;
        #1;
        reset_checks("midrst");
        @(negedge pclk);
        preset = 1'b0;
        #1;
        chk("midrst_cmd_ready", cmd_ready, 1);
        @(posedge pclk);
        #1;
        @(negedge pclk);
        chk("midrst_no_resume", psel, 0);
        chk("midrst_no_rsp", rsp_valid, 0);
        xfer(vecs[0]);

        for (int n = 0; n < 40; n++) begin
            rv.write = 1'($urandom);
            rv.addr  = 8'($urandom);
            rv.wdata = $urandom;
            rv.strb  = 4'($urandom);
            rv.waits = $urandom_range(0, 6);
            rv.err   = 1'($urandom);
            rv.rdata = $urandom;
            rv.park  = 1'($urandom);
            rv.delay = $urandom_range(0, 3);
            rv.early = 1'($urandom);
            rv.keep  = 1'b0;
            xfer(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb2_master.md
Name: apb2_master

Overview:
- APB2 initiator (requester) that turns single-beat commands from a local valid/ready port into APB2 SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response port.
- Drives the BLDC peripheral (and any other APB2 responder) from an on-chip sequencer or debug bridge.
- Includes an ACCESS-phase watchdog so a hung responder cannot stall the sequencer.

Parameters:
- data_width, 32, APB data width.
- addr_width, 8, APB address width.
- timeout_cycles, 256, maximum ACCESS cycles with pready low before abort; 0 disables the watchdog.
- prot_value, 3'b000, constant driven on pprot.

Ports:
- pclk  in  1  APB clock; single clock domain.
- preset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  addr_width  byte address.
- cmd_wdata  in  data_width  write data.
- cmd_strb  in  data_width/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  data_width  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslverr sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by the watchdog.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  addr_width.
- pwdata  out  data_width.
- pstrb  out  data_width/8.
- pprot  out  3.
- prdata  in  data_width.
- pready  in  1.
- pslverr  in  1.

Behaviour:
- Reset (async, preset=1): state IDLE. psel=penable=pwrite=0; paddr, pwdata, pstrb = 0; rsp_valid=0; rsp_rdata=0; rsp_err=rsp_timeout=0; watchdog counter=0.
- Reset asserted mid-transfer: bus drops immediately and the in-flight command is discarded with no response.
- pprot is always prot_value.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state==IDLE), registered, not combinational from cmd_valid.
- IDLE:
  - On cmd_valid&cmd_ready at edge N, latch write/addr/wdata/strb onto pwrite/paddr/pwdata/pstrb and go to SETUP.
  - For reads, pstrb is forced to 0.
- SETUP (cycle N+1): psel=1, penable=0. Always exactly one cycle, then ACCESS.
- ACCESS (cycle N+2 onward): psel=1, penable=1; pready is sampled only in this state.
  - pready=1: capture rsp_rdata = pwrite ? 0 : prdata; rsp_err = pslverr; rsp_timeout = 0. Next cycle psel=penable=0, state RESP.
  - pready=0: watchdog increments.
  - Watchdog: if timeout_cycles≠0 and the counter reaches timeout_cycles-1 with pready still low, abort. rsp_rdata=0, rsp_err=1, rsp_timeout=1, psel=penable=0, go to RESP.
  - pready and timeout in the same cycle: pready wins and the transfer completes normally.
- RESP: rsp_valid=1; outputs stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE and clear rsp_valid.
  - rsp_ready high before rsp_valid has no effect.
- paddr, pwdata and pwrite hold their last value outside SETUP/ACCESS. pstrb returns to 0 in IDLE.
- Latency: zero-wait transfer accepted at edge N gives rsp_valid in cycle N+3. Throughput is one transfer per 4 cycles with rsp_ready held high.
- Responders that park pready=1 while idle (the BLDC peripheral does) must not complete a transfer early. pready seen in IDLE or SETUP is ignored.
- Watchdog counter width is $clog2(timeout_cycles+1). It clears on entry to ACCESS and never wraps, saturating at its abort value.

Decomposition:
- Shared package apb2_types.sv holds:
  - apb2_master_state_t (IDLE, SETUP, ACCESS, RESP);
  - the apb2_rsp_t struct {rdata, err, timeout};
  - the APB2 width constants.
- One natural sub-module: apb2_watchdog (clear, count-enable, terminal flag, parameterised limit).

Test Plan:
- Read, zero wait: cmd read addr 8'h00; responder pready=1 in ACCESS, prdata=32'h0000_0A55. Required: psel high in cycles N+1 and N+2, penable only in N+2, rsp_valid in N+3 with rsp_rdata=32'h0000_0A55 and rsp_err=0.
- Write with 3 wait states: cmd write addr 8'h10, wdata 32'h5, strb 4'hF; pready low for 3 ACCESS cycles. Required: pwdata=32'h5 stable throughout; rsp_valid in N+6 with rsp_rdata=0 and rsp_err=0.
- Slave error plus early pready: responder holds pready=1 continuously and pslverr=1 in ACCESS. Required: no completion during SETUP; rsp_err=1 and rsp_timeout=0.
- Timeout: timeout_cycles=4 and pready tied 0. Required: abort after 4 ACCESS cycles; psel drops; rsp_err=1, rsp_timeout=1, rsp_rdata=0. A following command is then accepted normally.
- Response backpressure: rsp_ready=0 for 5 cycles with cmd_valid held high. Required: cmd_ready=0 throughout and rsp fields stable; the second command starts SETUP 2 cycles after rsp_ready rises.
- Reset mid-ACCESS: preset pulsed while penable=1. Required: psel, penable and rsp_valid are 0 before the next pclk edge; cmd_ready=1 once reset is released.
